// File: rtl/ccu_ctrl_pkg.sv
// ccu_ctrl_pkg: shared types and constants for the CCU controller writeback path.
//   wb_state_e  - writeback command FSM states
//   wb_entry_t  - one B-tracking table entry (valid + outgoing AXI ID)
//   ccu_*_t     - default AXI/ACE channel structs used by ccu_ctrl_wb_engine
package ccu_ctrl_pkg;

  localparam int unsigned CcuAddrWidth = 32;
  localparam int unsigned CcuIdWidth   = 6;   // MstIdxBits + SlvAxiIDWidth
  localparam int unsigned CcuDataWidth = 64;

  localparam logic [2:0] WB_SNOOP   = 3'b011;  // WriteBack snoop encoding
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    DATA
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [CcuIdWidth-1:0] id;
  } wb_entry_t;

  typedef struct packed {
    logic [CcuIdWidth-1:0]   id;
    logic [CcuAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [0:0]              user;
    logic [2:0]              snoop;
    logic [1:0]              bar;
    logic [1:0]              domain;
    logic                    awunique;
  } ccu_aw_chan_t;

  typedef struct packed {
    logic [CcuDataWidth-1:0]   data;
    logic [CcuDataWidth/8-1:0] strb;
    logic                      last;
    logic [0:0]                user;
  } ccu_w_chan_t;

  typedef struct packed {
    logic [CcuIdWidth-1:0] id;
    logic [1:0]            resp;
    logic [0:0]            user;
  } ccu_b_chan_t;

  typedef struct packed {
    logic [CcuDataWidth-1:0] data;
    logic                    last;
  } ccu_snoop_cd_t;

endpackage

// File: rtl/ccu_wb_id_table.sv
// ccu_wb_id_table: tracks IDs of writebacks whose B response is outstanding.
// Ports: clk_i, rst_i (async, active-high);
//        alloc_i/alloc_id_i  - claim the lowest free entry with this ID;
//        lookup_valid_i/lookup_id_i/lookup_hit_o - B beat ID match; a hit
//          while lookup_valid_i frees the lowest matching entry that cycle;
//        full_o - registered full flag;
//        query_id_i/query_hit_o - conflict query (CCU_WB_CONFLICT_CHECK_EN).
module ccu_wb_id_table
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned Entries = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_i,
  input  logic [CcuIdWidth-1:0] alloc_id_i,
  input  logic                  lookup_valid_i,
  input  logic [CcuIdWidth-1:0] lookup_id_i,
  output logic                  lookup_hit_o,
  output logic                  full_o,
  input  logic [CcuIdWidth-1:0] query_id_i,
  output logic                  query_hit_o
);
  wb_entry_t          r_table [Entries];
  logic               r_full;
  logic [Entries-1:0] w_valid, w_match, w_free_sel, w_alloc_sel, w_valid_next;

  genvar gi;
  generate
    for (gi = 0; gi < Entries; gi++) begin : g_match
      assign w_valid[gi] = r_table[gi].valid;
      assign w_match[gi] = r_table[gi].valid && (r_table[gi].id == lookup_id_i);
    end
  endgenerate

  // Lowest-index priority for both the entry to free and the entry to fill.
  always_comb begin
    logic found_free, found_alloc;
    w_free_sel  = '0;
    w_alloc_sel = '0;
    found_free  = 1'b0;
    found_alloc = 1'b0;
    for (int i = 0; i < Entries; i++) begin
      if (!found_free && w_match[i]) begin
        w_free_sel[i] = 1'b1;
        found_free    = 1'b1;
      end
      if (!found_alloc && !w_valid[i]) begin
        w_alloc_sel[i] = 1'b1;
        found_alloc    = 1'b1;
      end
    end
  end

  assign w_valid_next = (w_valid & ~(w_free_sel & {Entries{lookup_valid_i}}))
                      | (w_alloc_sel & {Entries{alloc_i}});
  assign lookup_hit_o = |w_match;
  assign full_o       = r_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Entries; i++) r_table[i] <= '0;
      r_full <= 1'b0;
    end else begin
      for (int i = 0; i < Entries; i++) begin
        if (alloc_i && w_alloc_sel[i]) begin
          r_table[i].valid <= 1'b1;
          r_table[i].id    <= alloc_id_i;
        end else if (lookup_valid_i && w_free_sel[i]) begin
          r_table[i].valid <= 1'b0;
        end
      end
      r_full <= &w_valid_next;
    end
  end

`ifdef CCU_WB_CONFLICT_CHECK_EN
  logic [Entries-1:0] w_qmatch;
  generate
    for (gi = 0; gi < Entries; gi++) begin : g_query
      assign w_qmatch[gi] = r_table[gi].valid && (r_table[gi].id == query_id_i);
    end
  endgenerate
  assign query_hit_o = |w_qmatch;
`else
  logic w_unused_query;
  assign w_unused_query = ^query_id_i;
  assign query_hit_o    = 1'b0;
`endif

endmodule

// File: rtl/fifo_v3.sv
// fifo_v3: small synchronous FIFO, not fall-through (data visible the cycle
// after push). Push while full and pop while empty are ignored.
// Ports: clk_i, rst_ni (async, active-low), flush_i, full_o, empty_o,
//        usage_o, data_i/push_i (write side), data_o/pop_i (read side).
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_DEPTH-1:0] r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]       r_count;
  logic                  w_push, w_pop;

  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign usage_o = r_count[ADDR_DEPTH-1:0];
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == ADDR_DEPTH'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == ADDR_DEPTH'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/ccu_ctrl_wb_engine.sv
// ccu_ctrl_wb_engine: turns a writeback command into a full-line AXI
// WriteBack burst. CD beats from the responder port feed the W channel via
// fifo_v3; other masked ports are drained. Outstanding writebacks are tracked
// so their B responses are absorbed; foreign B beats pass upstream.
// Optional macro: CCU_WB_CONFLICT_CHECK_EN enables query_hit_o.
// Ports: clk_i, rst_i (async, active-high); cmd_* command handshake;
//        aw_*/w_* memory write channels; mem_b_* B from memory;
//        b_* B upstream; cd_* snoop data per master; cd_busy_o;
//        query_id_i/query_hit_o ID-conflict query.
module ccu_ctrl_wb_engine
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned DcacheLineWidth  = 128,
  parameter int unsigned AxiDataWidth     = 64,
  parameter int unsigned NoMstPorts       = 4,
  parameter int unsigned SlvAxiIDWidth    = 4,
  parameter int unsigned MaxWbOutstanding = 4,
  parameter int unsigned FifoDepth        = 2,
  parameter type aw_chan_t  = ccu_aw_chan_t,
  parameter type w_chan_t   = ccu_w_chan_t,
  parameter type b_chan_t   = ccu_b_chan_t,
  parameter type snoop_cd_t = ccu_snoop_cd_t,
  localparam int unsigned MstIdxBits = $clog2(NoMstPorts)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [CcuAddrWidth-1:0]       cmd_addr_i,
  input  logic [SlvAxiIDWidth-1:0]      cmd_id_i,
  input  logic [MstIdxBits-1:0]         cmd_responder_i,
  input  logic [NoMstPorts-1:0]         cmd_mask_i,
  output aw_chan_t                      aw_o,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output w_chan_t                       w_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  input  b_chan_t                       mem_b_i,
  input  logic                          mem_b_valid_i,
  output logic                          mem_b_ready_o,
  output b_chan_t                       b_o,
  output logic                          b_valid_o,
  input  logic                          b_ready_i,
  input  snoop_cd_t                     cd_i [NoMstPorts],
  input  logic [NoMstPorts-1:0]         cd_valid_i,
  output logic [NoMstPorts-1:0]         cd_ready_o,
  output logic                          cd_busy_o,
  input  logic [MstIdxBits+SlvAxiIDWidth-1:0] query_id_i,
  output logic                          query_hit_o
);
  localparam int unsigned Words       = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned BeatBits    = $clog2(Words);
  localparam int unsigned LineOffBits = $clog2(DcacheLineWidth / 8);
  localparam int unsigned FifoUsageW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [CcuAddrWidth-1:0] LineMask =
    ~((CcuAddrWidth'(1) << LineOffBits) - CcuAddrWidth'(1));

  wb_state_e                r_state;
  logic                     r_live, r_aw_valid, r_cd_busy, r_w_done;
  logic [CcuAddrWidth-1:0]  r_addr;
  logic [SlvAxiIDWidth-1:0] r_id;
  logic [MstIdxBits-1:0]    r_resp;
  logic [NoMstPorts-1:0]    r_pending;
  logic [BeatBits-1:0]      r_beat;

  logic                    w_tbl_full, w_b_hit, w_cmd_hs, w_aw_hs, w_w_hs, w_w_last;
  logic                    w_w_done_now, w_cd_done_now;
  logic                    w_fifo_full, w_fifo_empty, w_push;
  logic [AxiDataWidth-1:0] w_fifo_data;
  logic [FifoUsageW-1:0]   w_unused_usage;
  logic [NoMstPorts-1:0]   w_cd_hs, w_cd_last_hs;

  // r_live keeps cmd_ready_o low while reset is held.
  assign cmd_ready_o = r_live && (r_state == IDLE) && !w_tbl_full;
  assign w_cmd_hs    = cmd_valid_i & cmd_ready_o;
  assign w_aw_hs     = r_aw_valid & aw_ready_i;
  assign w_w_hs      = w_valid_o & w_ready_i;
  assign w_w_last    = (r_beat == BeatBits'(Words - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NoMstPorts; gi++) begin : g_cd
      // Only the responder is throttled by the buffer; other ports drain freely.
      assign cd_ready_o[gi]   = r_pending[gi] &
                                ((r_resp != MstIdxBits'(gi)) | ~w_fifo_full);
      assign w_cd_hs[gi]      = cd_valid_i[gi] & cd_ready_o[gi];
      assign w_cd_last_hs[gi] = w_cd_hs[gi] & cd_i[gi].last;
    end
  endgenerate

  assign w_push        = w_cd_hs[r_resp];
  assign w_w_done_now  = r_w_done | (w_w_hs & w_w_last);
  assign w_cd_done_now = ((r_pending & ~w_cd_last_hs) == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_live     <= 1'b0;
      r_aw_valid <= 1'b0;
      r_cd_busy  <= 1'b0;
      r_w_done   <= 1'b0;
      r_addr     <= '0;
      r_id       <= '0;
      r_resp     <= '0;
      r_pending  <= '0;
      r_beat     <= '0;
    end else begin
      r_live    <= 1'b1;
      r_pending <= r_pending & ~w_cd_last_hs;
      if (w_w_hs) r_beat <= w_w_last ? '0 : r_beat + 1'b1;
      // W may finish while AW is still waiting, so remember it.
      if (w_w_hs && w_w_last) r_w_done <= 1'b1;
      case (r_state)
        IDLE: if (w_cmd_hs) begin
          r_addr     <= cmd_addr_i;
          r_id       <= cmd_id_i;
          r_resp     <= cmd_responder_i;
          r_pending  <= cmd_mask_i;
          r_w_done   <= 1'b0;
          r_aw_valid <= 1'b1;
          r_state    <= AW;
        end
        AW: if (w_aw_hs) begin
          r_aw_valid <= 1'b0;
          r_cd_busy  <= 1'b1;
          r_state    <= DATA;
        end
        DATA: if (w_w_done_now && w_cd_done_now) begin
          r_cd_busy <= 1'b0;
          r_w_done  <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign aw_valid_o = r_aw_valid;
  assign cd_busy_o  = r_cd_busy;

  always_comb begin
    aw_o        = '0;
    aw_o.addr   = r_addr & LineMask;
    aw_o.len    = 8'(Words - 1);
    aw_o.size   = 3'($clog2(AxiDataWidth / 8));
    aw_o.burst  = BURST_INCR;
    aw_o.id     = {r_resp, r_id};
    aw_o.domain = 2'b00;
    aw_o.snoop  = WB_SNOOP;
  end

  always_comb begin
    w_o      = '0;
    w_o.data = w_fifo_data;
    w_o.strb = '1;
    w_o.last = w_w_last;
  end
  assign w_valid_o = ~w_fifo_empty;

  fifo_v3 #(
    .DATA_WIDTH (AxiDataWidth),
    .DEPTH      (FifoDepth)
  ) i_wdata_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .usage_o (w_unused_usage),
    .data_i  (cd_i[r_resp].data),
    .push_i  (w_push),
    .data_o  (w_fifo_data),
    .pop_i   (w_ready_i)
  );

  ccu_wb_id_table #(
    .Entries (MaxWbOutstanding)
  ) i_id_table (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_i        (w_aw_hs),
    .alloc_id_i     ({r_resp, r_id}),
    .lookup_valid_i (mem_b_valid_i),
    .lookup_id_i    (mem_b_i.id),
    .lookup_hit_o   (w_b_hit),
    .full_o         (w_tbl_full),
    .query_id_i     (query_id_i),
    .query_hit_o    (query_hit_o)
  );

  // Own B beats are swallowed; everything else is a straight pass-through.
  assign b_o           = mem_b_i;
  assign b_valid_o     = mem_b_valid_i & ~w_b_hit;
  assign mem_b_ready_o = (mem_b_valid_i & w_b_hit) | (~w_b_hit & b_ready_i);

endmodule

// File: tb/tb_ccu_ctrl_wb_engine.sv
// Directed testbench for ccu_ctrl_wb_engine (FifoDepth=1 so buffer
// back-pressure on the responder port is directly visible).
module tb_ccu_ctrl_wb_engine;
  import ccu_ctrl_pkg::*;

`ifdef CCU_WB_CONFLICT_CHECK_EN
  localparam logic QHIT_EN = 1'b1;
`else
  localparam logic QHIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [31:0]   cmd_addr = '0;
  logic [3:0]    cmd_id = '0;
  logic [1:0]    cmd_resp = '0;
  logic [3:0]    cmd_mask = '0;
  ccu_aw_chan_t  aw;
  logic          aw_valid, aw_ready = 1'b0;
  ccu_w_chan_t   w;
  logic          w_valid, w_ready = 1'b0;
  ccu_b_chan_t   mem_b = '0;
  logic          mem_b_valid = 1'b0, mem_b_ready;
  ccu_b_chan_t   b;
  logic          b_valid, b_ready = 1'b0;
  ccu_snoop_cd_t cd [4];
  logic [3:0]    cd_valid = '0, cd_ready;
  logic          cd_busy;
  logic [5:0]    query_id = '0;
  logic          query_hit;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ccu_ctrl_wb_engine #(.FifoDepth(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_id_i(cmd_id), .cmd_responder_i(cmd_resp), .cmd_mask_i(cmd_mask),
    .aw_o(aw), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .w_o(w), .w_valid_o(w_valid), .w_ready_i(w_ready),
    .mem_b_i(mem_b), .mem_b_valid_i(mem_b_valid), .mem_b_ready_o(mem_b_ready),
    .b_o(b), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .cd_i(cd), .cd_valid_i(cd_valid), .cd_ready_o(cd_ready),
    .cd_busy_o(cd_busy), .query_id_i(query_id), .query_hit_o(query_hit)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [3:0] id,
                          input logic [1:0] r, input logic [3:0] m);
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_id = id; cmd_resp = r; cmd_mask = m;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic set_cd(input int p, input logic [63:0] d, input logic l);
    cd[p].data = d;
    cd[p].last = l;
  endtask

  // Single-responder writeback with W always ready; ends back in IDLE.
  task automatic do_wb(input logic [3:0] id, input logic [1:0] r);
    send_cmd(32'h2000 + {id, 8'h00}, id, r, 4'b0001 << r);
    w_ready = 1'b1;
    aw_ready = 1'b1;
    cd_valid[r] = 1'b1;
    set_cd(int'(r), 64'hF0 + id, 1'b0);
    step();
    aw_ready = 1'b0;
    set_cd(int'(r), 64'hF8 + id, 1'b1);
    step();
    step();
    cd_valid[r] = 1'b0;
    step();
    w_ready = 1'b0;
    chk("do_wb_back_idle_busy", cd_busy, 0);
  endtask

  task automatic absorb_b(input logic [5:0] id);
    mem_b.id = id; mem_b.resp = 2'b00; mem_b_valid = 1'b1;
    #1;
    chk("absorb_mem_b_ready", mem_b_ready, 1);
    chk("absorb_b_valid", b_valid, 0);
    step();
    mem_b_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cd[i] = '0;

    // Reset values.
    step(); step();
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_cd_ready", cd_ready, 0);
    chk("rst_cd_busy", cd_busy, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_mem_b_ready", mem_b_ready, 0);
    chk("rst_query_hit", query_hit, 0);
    rst = 1'b0;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Basic writeback: addr 0x1234, id 3, responder 2, mask 0100.
    send_cmd(32'h1234, 4'd3, 2'd2, 4'b0100);
    chk("t1_aw_valid", aw_valid, 1);
    chk("t1_aw_addr", aw.addr, 32'h1230);
    chk("t1_aw_len", aw.len, 1);
    chk("t1_aw_size", aw.size, 3);
    chk("t1_aw_burst", aw.burst, 2'b01);
    chk("t1_aw_id", aw.id, 6'h23);
    chk("t1_aw_snoop", aw.snoop, 3'b011);
    chk("t1_aw_domain", aw.domain, 0);
    chk("t1_cmd_ready_busy", cmd_ready, 0);
    chk("t1_cd_ready_aw", cd_ready, 4'b0100);
    step();
    chk("t1_aw_hold", aw_valid, 1);
    chk("t1_aw_addr_hold", aw.addr, 32'h1230);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    chk("t1_aw_done", aw_valid, 0);
    chk("t1_cd_busy", cd_busy, 1);
    cd_valid[2] = 1'b1; set_cd(2, 64'hA1A1, 1'b0);
    step();
    chk("t1_w_valid0", w_valid, 1);
    chk("t1_w_data0", w.data, 64'hA1A1);
    chk("t1_w_last0", w.last, 0);
    chk("t1_w_strb", w.strb, 8'hFF);
    chk("t1_cd_ready_full", cd_ready, 0);
    set_cd(2, 64'hA2A2, 1'b1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("t1_w_empty", w_valid, 0);
    chk("t1_cd_ready_free", cd_ready, 4'b0100);
    step();
    cd_valid[2] = 1'b0;
    chk("t1_w_data1", w.data, 64'hA2A2);
    chk("t1_w_last1", w.last, 1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("t1_done_busy", cd_busy, 0);
    chk("t1_done_ready", cmd_ready, 1);
    query_id = 6'h23;
    #1;
    chk("t1_query_pending", query_hit, QHIT_EN);
    absorb_b(6'h23);
    chk("t1_query_after_b", query_hit, 0);

    // Multi-port mask 1101, responder 0; ports 2/3 finish late.
    send_cmd(32'h4000, 4'd5, 2'd0, 4'b1101);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    chk("t2_cd_ready", cd_ready, 4'b1101);
    cd_valid[0] = 1'b1; set_cd(0, 64'hC1, 1'b0);
    step();
    chk("t2_w_data0", w.data, 64'hC1);
    set_cd(0, 64'hC2, 1'b1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    step();
    cd_valid[0] = 1'b0;
    chk("t2_w_data1", w.data, 64'hC2);
    chk("t2_w_last1", w.last, 1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("t2_ready_wait", cmd_ready, 0);
    chk("t2_busy_wait", cd_busy, 1);
    chk("t2_cd_ready_wait", cd_ready, 4'b1100);
    cd_valid[2] = 1'b1; set_cd(2, 64'hDEAD, 1'b1);
    step();
    cd_valid[2] = 1'b0;
    chk("t2_ready_p2", cmd_ready, 0);
    chk("t2_w_no_p2", w_valid, 0);
    chk("t2_cd_ready_p3", cd_ready, 4'b1000);
    cd_valid[3] = 1'b1; set_cd(3, 64'hBEEF, 1'b1);
    step();
    cd_valid[3] = 1'b0;
    chk("t2_ready_done", cmd_ready, 1);
    chk("t2_busy_done", cd_busy, 0);
    chk("t2_w_no_p3", w_valid, 0);
    absorb_b(6'h05);

    // W back-pressure for 10 cycles, responder 1.
    send_cmd(32'h8040, 4'd7, 2'd1, 4'b0010);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    cd_valid[1] = 1'b1; set_cd(1, 64'hB1, 1'b0);
    step();
    set_cd(1, 64'hB2, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("t3_cd_ready_stall", cd_ready, 0);
    chk("t3_w_hold_data", w.data, 64'hB1);
    chk("t3_w_hold_valid", w_valid, 1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("t3_cd_ready_resume", cd_ready, 4'b0010);
    step();
    cd_valid[1] = 1'b0;
    chk("t3_w_data1", w.data, 64'hB2);
    chk("t3_w_last1", w.last, 1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("t3_ready_done", cmd_ready, 1);
    absorb_b(6'h17);

    // Fill the table with four writebacks and hold their B responses.
    do_wb(4'd0, 2'd1);
    do_wb(4'd1, 2'd1);
    do_wb(4'd2, 2'd1);
    do_wb(4'd3, 2'd1);
    chk("t4_full_ready", cmd_ready, 0);
    step();
    chk("t4_full_ready_hold", cmd_ready, 0);
    absorb_b(6'h12);
    chk("t4_ready_after_free", cmd_ready, 1);
    absorb_b(6'h10);
    absorb_b(6'h11);
    absorb_b(6'h13);

    // Foreign B id 5 passes through.
    mem_b.id = 6'h05; mem_b.resp = 2'b10; mem_b_valid = 1'b1; b_ready = 1'b0;
    #1;
    chk("t5_b_valid", b_valid, 1);
    chk("t5_mem_b_ready_low", mem_b_ready, 0);
    chk("t5_b_id", b.id, 6'h05);
    chk("t5_b_resp", b.resp, 2'b10);
    step();
    chk("t5_b_valid_hold", b_valid, 1);
    b_ready = 1'b1;
    #1;
    chk("t5_mem_b_ready_high", mem_b_ready, 1);
    step();
    mem_b_valid = 1'b0; b_ready = 1'b0;

    // Reset in the middle of a writeback.
    send_cmd(32'h0100, 4'd1, 2'd0, 4'b0001);
    chk("t6_aw_valid_pre", aw_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_aw_valid_rst", aw_valid, 0);
    chk("t6_cd_ready_rst", cd_ready, 0);
    step();
    rst = 1'b0;
    step();
    query_id = 6'h01;
    #1;
    chk("t6_ready_after", cmd_ready, 1);
    chk("t6_query_cleared", query_hit, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
